// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: ALU writeback vs long-latency unit,
// plus busy-register scoreboard and decode stall generation.
module rf_wb_arbiter #(
    parameter int NREG       = 32,
    parameter int AW         = 5,
    parameter int DW         = 32,
    parameter int MAX_OUT    = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         alu_we,
    input  logic [AW-1:0]                alu_waddr,
    input  logic [DW-1:0]                alu_wdata,
    input  logic                         lu_valid,
    output logic                         lu_ready,
    input  logic [AW-1:0]                lu_waddr,
    input  logic [DW-1:0]                lu_wdata,
    input  logic                         dec_valid,
    input  logic                         dec_is_lu,
    input  logic [AW-1:0]                dec_rs1,
    input  logic [AW-1:0]                dec_rs2,
    input  logic [AW-1:0]                dec_rd,
    output logic                         stall,
    output logic                         rf_we,
    output logic [AW-1:0]                rf_waddr,
    output logic [DW-1:0]                rf_wdata,
    output logic [NREG-1:0]              busy,
    output logic [$clog2(MAX_OUT+1)-1:0] outstanding
);

    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic            alu_act;
    logic            lu_acc;
    logic            issue;
    logic            starve;
    logic            hazard;
    logic [SW-1:0]   starve_cnt;
    logic [SW-1:0]   starve_nx;
    logic [NREG-1:0] busy_nx;
    logic [OW-1:0]   out_nx;

    assign alu_act  = alu_we && (alu_waddr != '0);
    assign lu_ready = rst_n && !alu_act;
    assign lu_acc   = lu_valid && lu_ready;
    assign starve   = (starve_cnt == SW'(STARVE_MAX));

    // Depends only on registered state and decode inputs, never on lu_ready.
    assign hazard = busy[dec_rs1]
                 || busy[dec_rs2]
                 || ((dec_rd != '0) && busy[dec_rd])
                 || (dec_is_lu && (outstanding == OW'(MAX_OUT)))
                 || starve;

    assign stall = !rst_n || (dec_valid && hazard);
    assign issue = dec_valid && dec_is_lu && !stall;

    always_comb begin
        busy_nx = busy;
        if (lu_acc)
            busy_nx[lu_waddr] = 1'b0;
        if (issue && (dec_rd != '0))
            busy_nx[dec_rd] = 1'b1;
        busy_nx[0] = 1'b0;
    end

    always_comb begin
        out_nx = outstanding;
        case ({issue, lu_acc})
            2'b10: if (outstanding != OW'(MAX_OUT)) out_nx = outstanding + 1'b1;
            2'b01: if (outstanding != '0)           out_nx = outstanding - 1'b1;
            default: out_nx = outstanding;
        endcase
    end

    always_comb begin
        starve_nx = starve_cnt;
        if (lu_acc || !lu_valid)
            starve_nx = '0;
        else if (!starve)
            starve_nx = starve_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            busy        <= '0;
            outstanding <= '0;
            starve_cnt  <= '0;
        end else begin
            busy        <= busy_nx;
            outstanding <= out_nx;
            starve_cnt  <= starve_nx;
            if (alu_act) begin
                rf_we    <= 1'b1;
                rf_waddr <= alu_waddr;
                rf_wdata <= alu_wdata;
            end else if (lu_acc && (lu_waddr != '0)) begin
                rf_we    <= 1'b1;
                rf_waddr <= lu_waddr;
                rf_wdata <= lu_wdata;
            end else begin
                rf_we <= 1'b0;
            end
        end
    end

endmodule
